// File: rtl/seg7_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg7_scan_pkg;

    typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;

    function automatic int unsigned dwell_cycles(input int unsigned freq, input int unsigned rate);
        return freq / rate;
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Per-slot cycle counter; flags the last dead-time cycle and the last cycle of the slot.
module seg7_scan_timer #(
    parameter int unsigned DWELL       = 10,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic blank_done_c,
    output logic slot_done_c
);

    localparam int unsigned CW = $clog2(DWELL);

    logic [CW-1:0] cnt;

    assign blank_done_c = (cnt == CW'(DEAD_CYCLES - 1));
    assign slot_done_c  = (cnt == CW'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= slot_done_c ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame input snapshot and inter-digit dead time.
// Optional brightness PWM on the lit phase is enabled by defining SEG_SCAN_DIM_EN.
module seg7_scan_driver
    import seg7_scan_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned REFRESH_HZ  = 1_000,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic                  clk100_i,
    input  logic                  rst_i,
    input  logic [SEG_W-1:0]      hex0_i,
    input  logic [SEG_W-1:0]      hex1_i,
    input  logic [SEG_W-1:0]      hex2_i,
    input  logic [SEG_W-1:0]      hex3_i,
`ifdef SEG_SCAN_DIM_EN
    input  logic [2:0]            dim_i,
`endif
    output logic [NUM_DIGITS-1:0] an_o,
    output logic [SEG_W-1:0]      seg_o,
    output logic                  frame_o
);

    localparam int unsigned DWELL = dwell_cycles(CLK_FREQ_HZ, REFRESH_HZ);

    if (DEAD_CYCLES < 1 || DEAD_CYCLES > DWELL - 1) begin : g_bad_dead
        $error("seg7_scan_driver: DEAD_CYCLES must lie in 1..DWELL-1");
    end

    scan_state_t           state;
    logic [IDX_W-1:0]      idx;
    logic                  run;
    logic [SEG_W-1:0]      snap [NUM_DIGITS];
    logic                  blank_done_c;
    logic                  slot_done_c;
    logic                  take_snap_c;
    logic                  lit_c;
    logic [NUM_DIGITS-1:0] show_an_c;
    logic [NUM_DIGITS-1:0] lit_an_c;
    logic [SEG_W-1:0]      lit_seg_c;

    seg7_scan_timer #(
        .DWELL       (DWELL),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_timer (
        .clk          (clk100_i),
        .rst          (rst_i),
        .en           (run),
        .blank_done_c (blank_done_c),
        .slot_done_c  (slot_done_c)
    );

`ifdef SEG_SCAN_DIM_EN
    logic [2:0] pwm;
    logic [2:0] pwm_nxt_c;

    // Duty is judged against the pwm value live during the cycle the registered output lands in.
    assign pwm_nxt_c = pwm + 3'd1;
    assign lit_c     = ({1'b0, pwm_nxt_c} < ({1'b0, dim_i} + 4'd1));

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            pwm <= '0;
        end else begin
            pwm <= pwm_nxt_c;
        end
    end
`else
    assign lit_c = 1'b1;
`endif

    assign show_an_c = ~(NUM_DIGITS'(1) << idx);
    assign lit_an_c  = lit_c ? show_an_c : AN_OFF;
    assign lit_seg_c = lit_c ? snap[idx] : SEG_OFF;

    // A frame begins on the first edge out of reset and on the edge leaving the last digit's slot.
    assign take_snap_c = !run
                       || (state == ST_SHOW && slot_done_c && idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= SEG_OFF;
        end else if (take_snap_c) begin
            snap[0] <= hex0_i;
            snap[1] <= hex1_i;
            snap[2] <= hex2_i;
            snap[3] <= hex3_i;
        end
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            state   <= ST_BLANK;
            idx     <= '0;
            run     <= 1'b0;
            frame_o <= 1'b0;
            an_o    <= AN_OFF;
            seg_o   <= SEG_OFF;
        end else begin
            frame_o <= take_snap_c;
            an_o    <= AN_OFF;
            seg_o   <= SEG_OFF;
            if (!run) begin
                run <= 1'b1;
            end else begin
                case (state)
                    ST_BLANK: begin
                        if (blank_done_c) begin
                            state <= ST_SHOW;
                            an_o  <= lit_an_c;
                            seg_o <= lit_seg_c;
                        end
                    end
                    ST_SHOW: begin
                        if (slot_done_c) begin
                            state <= ST_BLANK;
                            idx   <= idx + IDX_W'(1);
                        end else begin
                            an_o  <= lit_an_c;
                            seg_o <= lit_seg_c;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a frame/slot arithmetic model (DWELL=10, dead=2).
module tb_seg7_scan_driver;

    localparam int unsigned DWELL = 10;
    localparam int unsigned DEAD  = 2;
    localparam int unsigned FRAME = 4 * DWELL;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] h0, h1, h2, h3;
    logic [2:0] dim;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .CLK_FREQ_HZ (1000),
        .REFRESH_HZ  (100),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk100_i (clk),
        .rst_i    (rst),
        .hex0_i   (h0),
        .hex1_i   (h1),
        .hex2_i   (h2),
        .hex3_i   (h3),
`ifdef SEG_SCAN_DIM_EN
        .dim_i    (dim),
`endif
        .an_o     (an),
        .seg_o    (seg),
        .frame_o  (frame)
    );

    int         total = 0;
    int         bad   = 0;
    int         t     = 0;
    int         lit_cnt = 0;
    bit         started = 1'b0;
    logic [6:0] ref_snap [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
        end
    endtask

    // Advance one clock and compare outputs against the model for the cycle just entered.
    task automatic cycle();
        int         pos;
        int         slot;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        @(posedge clk);
        #1;
        if (rst) begin
            started = 1'b0;
            lit_cnt = 0;
            check_eq("rst_an", 32'(an), 32'hF);
            check_eq("rst_seg", 32'(seg), 32'h7F);
            check_eq("rst_frame", 32'(frame), 32'd0);
        end else begin
            if (!started) begin
                started = 1'b1;
                t = 0;
            end else begin
                t++;
            end
            pos  = t % DWELL;
            slot = (t / DWELL) % 4;
            if (t % FRAME == 0) begin
                ref_snap[0] = h0;
                ref_snap[1] = h1;
                ref_snap[2] = h2;
                ref_snap[3] = h3;
            end
            check_eq("frame", 32'(frame), (t % FRAME == 0) ? 32'd1 : 32'd0);
            exp_an  = (pos < DEAD) ? 4'hF : ~(4'b0001 << slot);
            exp_seg = (pos < DEAD) ? 7'h7F : ref_snap[slot];
`ifdef SEG_SCAN_DIM_EN
            if (an != 4'hF) begin
                lit_cnt++;
                check_eq("dim_an", 32'(an), 32'(exp_an));
                check_eq("dim_seg", 32'(seg), 32'(exp_seg));
            end
            if (pos == DWELL - 1) begin
                check_eq("dim_duty", 32'(lit_cnt), 32'(dim) + 32'd1);
                lit_cnt = 0;
            end
`else
            check_eq("an", 32'(an), 32'(exp_an));
            check_eq("seg", 32'(seg), 32'(exp_seg));
`endif
        end
        check_eq("one_low", 32'($countones(~an) <= 1), 32'd1);
        if (an == 4'hF) check_eq("dark_seg", 32'(seg), 32'h7F);
    endtask

    initial begin
        rst = 1'b1;
        dim = 3'd3;
        h0  = 7'($urandom);
        h1  = 7'($urandom);
        h2  = 7'($urandom);
        h3  = 7'($urandom);
        repeat (3) cycle();

        h0  = 7'h40;
        h1  = 7'h79;
        h2  = 7'h24;
        h3  = 7'h30;
        rst = 1'b0;
        repeat (41) cycle();

        // Mid-frame change must wait for the next frame boundary.
        while (t % FRAME != 5) cycle();
        h2 = 7'h12;
        repeat (80) cycle();

        while (t % FRAME != FRAME - 1) cycle();
        dim = 3'd7;
        repeat (80) cycle();

        while (t % FRAME != 15) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (60) cycle();

        repeat (600) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: h0 = 7'($urandom);
                    1: h1 = 7'($urandom);
                    2: h2 = 7'($urandom);
                    default: h3 = 7'($urandom);
                endcase
            end
            if (t % DWELL == DWELL - 1) dim = 3'($urandom);
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            cycle();
            rst = 1'b0;
        end

        repeat (45) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
